if_prefetch_queue: RTL and testbench

Parametrised instruction-fetch front end that replaces the single PC register plus direct instruction-bus path with a fetch engine and a DEPTH-entry prefetch FIFO. It drives the instruction memory bus (IAD/IDT/ACKI_n) with a proper wait-state handshake, buffers fetched {pc, pc+4, instruction} tuples, and presents them to the IF/ID pipeline register via a valid/ready interface. Branch/jump redirects flush the queue and cleanly discard any in-flight bus beat.

---
 rtl/if_prefetch_queue.sv | 132 +++++++++++++
 tb/tb_if_prefetch_queue.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: a wait-state aware bus fetch engine feeding a
// DEPTH-entry prefetch FIFO of {pc, inst} that drains into IF/ID over valid/ready.
module if_prefetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     ireq,
  output logic [XLEN-1:0]          iad,
  input  logic [31:0]              idt,
  input  logic                     acki_n,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_pc4,
  output logic [31:0]              out_inst,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]   FULL    = CW'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic {RUN, FLUSH_WAIT} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] fetch_pc, fetch_nxt;
  logic [XLEN-1:0] pend_pc, pend_nxt;
  logic            started;
  logic            push, pop;
  logic [XLEN-1:0] redirect_addr;

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [31:0]     inst_mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   occ;

  assign redirect_addr = redirect_pc & ~XLEN'(3);

  // started keeps ireq low until the first clock edge after reset is released
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      fetch_pc <= RESET_PC;
      pend_pc  <= RESET_PC;
      started  <= 1'b0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_nxt;
      pend_pc  <= pend_nxt;
      started  <= 1'b1;
    end
  end

  // In FLUSH_WAIT fetch_pc still holds the outstanding address, so iad stays put
  // until the stale beat is acked; pend_pc remembers where to go afterwards.
  always_comb begin
    state_nxt = state;
    fetch_nxt = fetch_pc;
    pend_nxt  = pend_pc;
    ireq      = 1'b0;
    push      = 1'b0;
    case (state)
      RUN: begin
        ireq = started && (occ != FULL);
        if (redirect) begin
          if (ireq && acki_n) begin
            pend_nxt  = redirect_addr;
            state_nxt = FLUSH_WAIT;
          end else begin
            fetch_nxt = redirect_addr;
          end
        end else if (ireq && !acki_n) begin
          push      = 1'b1;
          fetch_nxt = fetch_pc + PC_STEP;
        end
      end
      FLUSH_WAIT: begin
        ireq = 1'b1;
        if (!acki_n) begin
          fetch_nxt = redirect ? redirect_addr : pend_pc;
          state_nxt = RUN;
        end else if (redirect) begin
          pend_nxt = redirect_addr;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  assign iad       = fetch_pc;
  assign out_valid = (occ != '0);
  assign pop       = out_valid && out_ready && !redirect;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= fetch_pc;
      inst_mem[wr_ptr] <= idt;
    end
  end

  assign out_pc   = pc_mem[rd_ptr];
  assign out_pc4  = out_pc + PC_STEP;
  assign out_inst = inst_mem[rd_ptr];
  assign count    = occ;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Self-checking bench for if_prefetch_queue: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_if_prefetch_queue;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        ireq;
  logic [31:0] iad;
  logic [31:0] idt = '0;
  logic        acki_n = 1'b1;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc, out_pc4, out_inst;
  logic [2:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  if_prefetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .ireq(ireq), .iad(iad), .idt(idt), .acki_n(acki_n),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_pc4(out_pc4), .out_inst(out_inst), .count(count)
  );

  always #5 clk = ~clk;

  // Reference model: queue of fetched entries, the address the front end is
  // presenting, and whether the outstanding beat belongs to a flushed stream.
  logic [31:0] mq_pc[$];
  logic [31:0] mq_inst[$];
  logic [31:0] m_addr;
  logic [31:0] m_after;
  bit          m_discard;
  bit          m_started;
  int          wait_cnt;

  function automatic bit m_ireq();
    return m_started && (m_discard || (mq_pc.size() < DEPTH));
  endfunction

  function automatic logic [36:0] exp_status();
    return {m_ireq(), m_addr, (mq_pc.size() != 0), 3'(mq_pc.size())};
  endfunction

  function automatic logic [95:0] exp_head();
    return {mq_pc[0], mq_pc[0] + 32'd4, mq_inst[0]};
  endfunction

  task automatic model_reset();
    mq_pc.delete();
    mq_inst.delete();
    m_addr    = RESET_PC;
    m_after   = '0;
    m_discard = 0;
    m_started = 0;
    wait_cnt  = 0;
  endtask

  task automatic model_step();
    bit          req = m_ireq();
    bit          ack = req && !acki_n;
    logic [31:0] rp  = redirect_pc & 32'hFFFF_FFFC;
    if (redirect) begin
      mq_pc.delete();
      mq_inst.delete();
      if (m_discard) begin
        if (ack) begin m_discard = 0; m_addr = rp; end
        else m_after = rp;
      end else if (req && !ack) begin
        m_discard = 1;
        m_after   = rp;
      end else begin
        m_addr = rp;
      end
    end else begin
      if (out_ready && mq_pc.size() > 0) begin
        void'(mq_pc.pop_front());
        void'(mq_inst.pop_front());
      end
      if (m_discard) begin
        if (ack) begin m_discard = 0; m_addr = m_after; end
      end else if (ack) begin
        mq_pc.push_back(m_addr);
        mq_inst.push_back(idt);
        m_addr = m_addr + 32'd4;
      end
    end
    m_started = 1;
  endtask

  // One clock: drive inputs at the falling edge, advance the model, return at the next falling edge
  task automatic tick(input logic r, input logic [31:0] rpc, input logic ackn,
                      input logic rdy, input logic [31:0] data);
    redirect = r; redirect_pc = rpc; acki_n = ackn; out_ready = rdy; idt = data;
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Memory responder with ws wait states per beat
  task automatic mem_tick(input int ws, input logic r, input logic [31:0] rpc, input logic rdy);
    logic an;
    if (!m_ireq()) begin wait_cnt = 0; an = 1'b1; end
    else if (wait_cnt >= ws) begin wait_cnt = 0; an = 1'b0; end
    else begin wait_cnt++; an = 1'b1; end
    tick(r, rpc, an, rdy, $urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0; acki_n = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({ireq, iad, out_valid, count} !== {1'b0, RESET_PC, 1'b0, 3'd0}) begin
      n_errors++;
      $display("[TB] FAIL reset_state: got %h expected %h", {ireq, iad, out_valid, count}, {1'b0, RESET_PC, 1'b0, 3'd0});
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    n_checks++;
    if (ireq !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL reset_release_ireq: got %b expected 0", ireq);
    end
    tick(1'b0, '0, 1'b1, 1'b0, '0);
    n_checks++;
    if ({ireq, iad, out_valid} !== {1'b1, RESET_PC, 1'b0}) begin
      n_errors++;
      $display("[TB] FAIL first_request: got %h expected %h", {ireq, iad, out_valid}, {1'b1, RESET_PC, 1'b0});
    end
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 14; i++) begin
      tick(1'b0, '0, 1'b0, 1'b1, $urandom);
      n_checks++;
      if ({ireq, iad, out_valid, count} !== exp_status()) begin
        n_errors++;
        $display("[TB] FAIL stream_status cyc %0d: got %h expected %h", i, {ireq, iad, out_valid, count}, exp_status());
      end
      if (mq_pc.size() != 0) begin
        n_checks++;
        if ({out_pc, out_pc4, out_inst} !== exp_head()) begin
          n_errors++;
          $display("[TB] FAIL stream_head cyc %0d: got %h expected %h", i, {out_pc, out_pc4, out_inst}, exp_head());
        end
      end
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 7; i++) tick(1'b0, '0, 1'b0, 1'b0, $urandom);
    n_checks++;
    if ({ireq, iad, count, out_pc} !== {1'b0, 32'h10, 3'd4, 32'h0}) begin
      n_errors++;
      $display("[TB] FAIL full_hold: got %h expected %h", {ireq, iad, count, out_pc}, {1'b0, 32'h10, 3'd4, 32'h0});
    end
    tick(1'b0, '0, 1'b0, 1'b1, $urandom);
    n_checks++;
    if ({ireq, iad, count, out_pc} !== {1'b1, 32'h10, 3'd3, 32'h4}) begin
      n_errors++;
      $display("[TB] FAIL full_reopen: got %h expected %h", {ireq, iad, count, out_pc}, {1'b1, 32'h10, 3'd3, 32'h4});
    end
  endtask

  task automatic test_wait_states();
    do_reset();
    for (int i = 0; i < 21; i++) begin
      mem_tick(3, 1'b0, '0, (i >= 13));
      n_checks++;
      if ({ireq, iad, out_valid, count} !== exp_status()) begin
        n_errors++;
        $display("[TB] FAIL wait_status cyc %0d: got %h expected %h", i, {ireq, iad, out_valid, count}, exp_status());
      end
      if (i == 12) begin
        n_checks++;
        if (count !== 3'd3) begin
          n_errors++;
          $display("[TB] FAIL wait_count: got %0d expected 3", count);
        end
      end
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    tick(1'b0, '0, 1'b1, 1'b0, '0);
    tick(1'b0, '0, 1'b0, 1'b0, $urandom);
    tick(1'b0, '0, 1'b0, 1'b0, $urandom);
    tick(1'b0, '0, 1'b1, 1'b0, '0);
    tick(1'b1, 32'h100, 1'b1, 1'b0, '0);
    n_checks++;
    if ({ireq, iad, out_valid, count} !== {1'b1, 32'h8, 1'b0, 3'd0}) begin
      n_errors++;
      $display("[TB] FAIL redir_wait_flush: got %h expected %h", {ireq, iad, out_valid, count}, {1'b1, 32'h8, 1'b0, 3'd0});
    end
    tick(1'b0, '0, 1'b1, 1'b1, '0);
    tick(1'b0, '0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    n_checks++;
    if ({ireq, iad, out_valid} !== {1'b1, 32'h100, 1'b0}) begin
      n_errors++;
      $display("[TB] FAIL redir_wait_resume: got %h expected %h", {ireq, iad, out_valid}, {1'b1, 32'h100, 1'b0});
    end
    tick(1'b0, '0, 1'b0, 1'b1, 32'h1234_5678);
    n_checks++;
    if ({out_valid, out_pc, out_inst} !== {1'b1, 32'h100, 32'h1234_5678}) begin
      n_errors++;
      $display("[TB] FAIL redir_wait_head: got %h expected %h", {out_valid, out_pc, out_inst}, {1'b1, 32'h100, 32'h1234_5678});
    end
  endtask

  task automatic test_redirect_ack();
    do_reset();
    for (int i = 0; i < 4; i++) tick(1'b0, '0, 1'b0, 1'b1, $urandom);
    tick(1'b1, 32'h200, 1'b0, 1'b1, 32'hBAD0_0001);
    n_checks++;
    if ({ireq, iad, out_valid, count} !== {1'b1, 32'h200, 1'b0, 3'd0}) begin
      n_errors++;
      $display("[TB] FAIL redir_ack: got %h expected %h", {ireq, iad, out_valid, count}, {1'b1, 32'h200, 1'b0, 3'd0});
    end
    tick(1'b0, '0, 1'b1, 1'b1, '0);
    tick(1'b1, 32'h280, 1'b1, 1'b1, '0);
    n_checks++;
    if ({ireq, iad, out_valid} !== {1'b1, 32'h200, 1'b0}) begin
      n_errors++;
      $display("[TB] FAIL flush_hold: got %h expected %h", {ireq, iad, out_valid}, {1'b1, 32'h200, 1'b0});
    end
    tick(1'b1, 32'h302, 1'b1, 1'b1, '0);
    tick(1'b0, '0, 1'b0, 1'b1, 32'hBAD0_0002);
    n_checks++;
    if ({ireq, iad, out_valid} !== {1'b1, 32'h300, 1'b0}) begin
      n_errors++;
      $display("[TB] FAIL flush_last_redirect: got %h expected %h", {ireq, iad, out_valid}, {1'b1, 32'h300, 1'b0});
    end
    tick(1'b0, '0, 1'b0, 1'b0, 32'h0C0F_FEE0);
    n_checks++;
    if ({out_valid, out_pc, out_pc4, out_inst} !== {1'b1, 32'h300, 32'h304, 32'h0C0F_FEE0}) begin
      n_errors++;
      $display("[TB] FAIL flush_first_entry: got %h expected %h", {out_valid, out_pc, out_pc4, out_inst}, {1'b1, 32'h300, 32'h304, 32'h0C0F_FEE0});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 11; i++) mem_tick(3, 1'b0, '0, 1'b0);
    n_checks++;
    if (count !== 3'd2) begin
      n_errors++;
      $display("[TB] FAIL reset_mid_pre_count: got %0d expected 2", count);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({ireq, iad, out_valid, count} !== {1'b0, RESET_PC, 1'b0, 3'd0}) begin
      n_errors++;
      $display("[TB] FAIL reset_mid_async: got %h expected %h", {ireq, iad, out_valid, count}, {1'b0, RESET_PC, 1'b0, 3'd0});
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    tick(1'b0, '0, 1'b1, 1'b0, '0);
    n_checks++;
    if ({ireq, iad} !== {1'b1, RESET_PC}) begin
      n_errors++;
      $display("[TB] FAIL reset_mid_restart: got %h expected %h", {ireq, iad}, {1'b1, RESET_PC});
    end
  endtask

  task automatic test_random();
    int ws = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic        r;
      logic [31:0] rpc;
      if (wait_cnt == 0) ws = $urandom_range(0, 2);
      r   = ($urandom_range(0, 11) == 0);
      rpc = $urandom & 32'h0000_FFFF;
      mem_tick(ws, r, rpc, ($urandom_range(0, 3) != 0));
      n_checks++;
      if ({ireq, iad, out_valid, count} !== exp_status()) begin
        n_errors++;
        $display("[TB] FAIL random_status cyc %0d: got %h expected %h", i, {ireq, iad, out_valid, count}, exp_status());
      end
      if (mq_pc.size() != 0) begin
        n_checks++;
        if ({out_pc, out_pc4, out_inst} !== exp_head()) begin
          n_errors++;
          $display("[TB] FAIL random_head cyc %0d: got %h expected %h", i, {out_pc, out_pc4, out_inst}, exp_head());
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stream();
    test_full();
    test_wait_states();
    test_redirect_wait();
    test_redirect_ack();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
